// File: rtl/axi_helper_pkg.sv
// Shared types for the AXI manager: response encoding, FSM state encoding
// and the saturating error-counter helper.
package axi_helper;

    // AXI response codes carried on BDATA and reported on rsp_resp.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Manager FSM states; only one transaction is ever in flight.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } mgr_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Increment an 8-bit counter, holding at its ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == ERR_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// Simplified AXI4 bus bundle: address/data/response channels with a
// manager view (drives requests) and a subordinate view (answers them).
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWDATA;

    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;

    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BDATA;

    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARDATA;

    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;

    modport manager (
        output AWVALID, input  AWREADY, output AWDATA,
        output WVALID,  input  WREADY,  output WDATA,
        input  BVALID,  output BREADY,  input  BDATA,
        output ARVALID, input  ARREADY, output ARDATA,
        input  RVALID,  output RREADY,  input  RDATA
    );

    modport subordinate (
        input  AWVALID, output AWREADY, input  AWDATA,
        input  WVALID,  output WREADY,  input  WDATA,
        output BVALID,  input  BREADY,  output BDATA,
        input  ARVALID, output ARREADY, input  ARDATA,
        output RVALID,  input  RREADY,  output RDATA
    );

endinterface

// File: rtl/axi_manager.sv
// Single-outstanding AXI manager: accepts one local command, issues it on
// the bus (AW+W or AR), waits for the B or R response and presents the
// completion on the local response handshake. All bus and local outputs
// come straight from registers so no VALID can follow a READY combinationally.
module axi_manager
    import axi_helper::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    axi4_if.manager           bus,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic [7:0]        err_cnt
);

    mgr_state_t        state_r;

    logic              awvalid_r;
    logic              wvalid_r;
    logic              arvalid_r;
    logic              bready_r;
    logic              rready_r;
    logic              aw_done_r;
    logic              w_done_r;

    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic              rsp_write_r;
    logic [1:0]        rsp_resp_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic [7:0]        err_cnt_r;

    logic              cmd_hs_s;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              ar_hs_s;
    logic              b_hs_s;
    logic              r_hs_s;
    logic              rsp_hs_s;
    logic              aw_complete_s;
    logic              w_complete_s;

    // Handshake decodes; READY inputs only qualify registered VALIDs.
    assign cmd_hs_s      = cmd_valid   & cmd_ready_r;
    assign aw_hs_s       = awvalid_r   & bus.AWREADY;
    assign w_hs_s        = wvalid_r    & bus.WREADY;
    assign ar_hs_s       = arvalid_r   & bus.ARREADY;
    assign b_hs_s        = bready_r    & bus.BVALID;
    assign r_hs_s        = rready_r    & bus.RVALID;
    assign rsp_hs_s      = rsp_valid_r & rsp_ready;
    assign aw_complete_s = aw_done_r   | aw_hs_s;
    assign w_complete_s  = w_done_r    | w_hs_s;

    // Transaction FSM with its registered bus/local outputs and error counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r     <= IDLE;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_resp_r  <= OKAY;
            rsp_rdata_r <= {DATA_W{1'b0}};
            err_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_hs_s) begin
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        cmd_ready_r <= 1'b0;
                        if (cmd_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; either may finish first.
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_complete_s && w_complete_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (b_hs_s) begin
                        bready_r    <= 1'b0;
                        rsp_resp_r  <= bus.BDATA;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        rsp_write_r <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= DONE;
                        if (bus.BDATA != OKAY) begin
                            err_cnt_r <= sat_inc8(err_cnt_r);
                        end
                    end
                end

                RD_REQ: begin
                    if (ar_hs_s) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    // Read responses are always reported as OKAY.
                    if (r_hs_s) begin
                        rready_r    <= 1'b0;
                        rsp_rdata_r <= bus.RDATA;
                        rsp_resp_r  <= OKAY;
                        rsp_write_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end

                DONE: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end

                default: begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    aw_done_r   <= 1'b0;
                    w_done_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.AWVALID = awvalid_r;
    assign bus.AWDATA  = addr_r;
    assign bus.WVALID  = wvalid_r;
    assign bus.WDATA   = wdata_r;
    assign bus.BREADY  = bready_r;
    assign bus.ARVALID = arvalid_r;
    assign bus.ARDATA  = addr_r;
    assign bus.RREADY  = rready_r;

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_write = rsp_write_r;
    assign rsp_resp  = rsp_resp_r;
    assign rsp_rdata = rsp_rdata_r;
    assign err_cnt   = err_cnt_r;

endmodule
